// File: rtl/mean_pkg.sv
// Shared definitions for the mean_window averaging filter.
package mean_pkg;

  localparam int MODE_BLOCK = 0;
  localparam int MODE_SLIDE = 1;

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_RUN  = 2'd1,
    ST_ACC  = 2'd2
  } state_t;

  // Sum of 2**log2_n samples of data_w bits can never exceed this width.
  function automatic int acc_w(input int data_w, input int log2_n);
    return data_w + log2_n;
  endfunction

endpackage

// File: rtl/mean_delay_line.sv
// N-entry circular sample buffer; the slot at wr_ptr always holds the oldest sample.
module mean_delay_line
  import mean_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int LOG2_N = 11
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [LOG2_N-1:0] wr_ptr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [2**LOG2_N];

  assign rd_data = mem[wr_ptr];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/mean_window.sv
// Block or sliding mean of 2**LOG2_N signed Q1.(DATA_W-1) samples, optional round-half-up.
//
//  state   | meaning
//  ST_ACC  | block mode: accumulating, result on every Nth accept
//  ST_FILL | sliding mode: warm-up, delay line not yet full
//  ST_RUN  | sliding mode: window full, result on every accept
module mean_window
  import mean_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int LOG2_N = 11,
  parameter int MODE   = 0,
  parameter int ROUND  = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              valid_out,
  output logic [DATA_W-1:0] mean_out,
  output logic              primed
);

  localparam int ACC_W = acc_w(DATA_W, LOG2_N);
  localparam int N = 2**LOG2_N;
  localparam logic [LOG2_N-1:0] CNT_LAST = LOG2_N'(N - 1);
  localparam int RND_I = (ROUND != 0) ? 2**(LOG2_N-1) : 0;
  localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W+1)'((2**(DATA_W-1)) - 1);
  // Block mode has a single state; only the sliding mode starts in FILL.
  localparam state_t ST_INIT = (MODE == MODE_SLIDE) ? ST_FILL : ST_ACC;

  state_t state, state_nxt;
  logic signed [ACC_W-1:0] acc, acc_nxt, acc_sum, x_ext, old_ext;
  logic signed [ACC_W:0] rnd_sum, shifted;
  logic [LOG2_N-1:0] cnt, cnt_nxt;
  logic [DATA_W-1:0] oldest, result;
  logic primed_nxt, emit;

  assign x_ext   = {{LOG2_N{data_in[DATA_W-1]}}, data_in};
  assign old_ext = (state == ST_RUN) ? {{LOG2_N{oldest[DATA_W-1]}}, oldest} : '0;
  assign acc_sum = acc + x_ext - old_ext;

  assign rnd_sum = {acc_sum[ACC_W-1], acc_sum} + (ACC_W+1)'(RND_I);
  assign shifted = rnd_sum >>> LOG2_N;
  // Only the rounding increment can push the quotient past full scale.
  assign result  = (shifted > SAT_MAX) ? SAT_MAX[DATA_W-1:0] : shifted[DATA_W-1:0];

  always_comb begin
    state_nxt  = state;
    acc_nxt    = acc;
    cnt_nxt    = cnt;
    primed_nxt = primed;
    emit       = 1'b0;
    if (clear) begin
      state_nxt  = ST_INIT;
      acc_nxt    = '0;
      cnt_nxt    = '0;
      primed_nxt = 1'b0;
    end else if (valid_in) begin
      case (state)
        ST_ACC: begin
          if (cnt == CNT_LAST) begin
            emit    = 1'b1;
            acc_nxt = '0;
            cnt_nxt = '0;
          end else begin
            acc_nxt = acc_sum;
            cnt_nxt = cnt + 1'b1;
          end
        end
        ST_FILL: begin
          acc_nxt = acc_sum;
          cnt_nxt = cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            emit       = 1'b1;
            state_nxt  = ST_RUN;
            primed_nxt = 1'b1;
            cnt_nxt    = '0;
          end
        end
        ST_RUN: begin
          acc_nxt = acc_sum;
          emit    = 1'b1;
        end
        default: state_nxt = ST_INIT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_INIT;
      acc       <= '0;
      cnt       <= '0;
      primed    <= 1'b0;
      valid_out <= 1'b0;
      mean_out  <= '0;
    end else begin
      state     <= state_nxt;
      acc       <= acc_nxt;
      cnt       <= cnt_nxt;
      primed    <= primed_nxt;
      valid_out <= emit;
      if (emit) mean_out <= result;
    end
  end

  if (MODE == MODE_SLIDE) begin : g_slide
    logic [LOG2_N-1:0] wr_ptr;
    logic              wr_en;

    assign wr_en = valid_in & ~clear;

    always_ff @(posedge clk or posedge rst) begin
      if (rst)        wr_ptr <= '0;
      else if (clear) wr_ptr <= '0;
      else if (wr_en) wr_ptr <= wr_ptr + 1'b1;
    end

    mean_delay_line #(
      .DATA_W (DATA_W),
      .LOG2_N (LOG2_N)
    ) u_delay_line (
      .clk     (clk),
      .wr_en   (wr_en),
      .wr_ptr  (wr_ptr),
      .wr_data (data_in),
      .rd_data (oldest)
    );
  end else begin : g_block
    assign oldest = '0;
  end

endmodule

// File: tb/tb_mean_window.sv
// Directed bench: block (N=2048), sliding (N=4) and rounding (N=4) instances of mean_window.
module tb_mean_window;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // A: block, LOG2_N=11
  logic a_clr = 0, a_vi = 0, a_vo, a_pr;
  logic [15:0] a_d = 0, a_mean;
  // B: sliding, LOG2_N=2
  logic b_clr = 0, b_vi = 0, b_vo, b_pr;
  logic [15:0] b_d = 0, b_mean;
  // C/D: block LOG2_N=2, floor and round, shared stimulus
  logic c_clr = 0, c_vi = 0, c_vo, c_pr, d_vo, d_pr;
  logic [15:0] c_d = 0, c_mean, d_mean;

  mean_window #(.DATA_W(16), .LOG2_N(11), .MODE(0), .ROUND(0)) u_a (
    .clk(clk), .rst(rst), .clear(a_clr), .valid_in(a_vi), .data_in(a_d),
    .valid_out(a_vo), .mean_out(a_mean), .primed(a_pr));
  mean_window #(.DATA_W(16), .LOG2_N(2), .MODE(1), .ROUND(0)) u_b (
    .clk(clk), .rst(rst), .clear(b_clr), .valid_in(b_vi), .data_in(b_d),
    .valid_out(b_vo), .mean_out(b_mean), .primed(b_pr));
  mean_window #(.DATA_W(16), .LOG2_N(2), .MODE(0), .ROUND(0)) u_c (
    .clk(clk), .rst(rst), .clear(c_clr), .valid_in(c_vi), .data_in(c_d),
    .valid_out(c_vo), .mean_out(c_mean), .primed(c_pr));
  mean_window #(.DATA_W(16), .LOG2_N(2), .MODE(0), .ROUND(1)) u_d (
    .clk(clk), .rst(rst), .clear(c_clr), .valid_in(c_vi), .data_in(c_d),
    .valid_out(d_vo), .mean_out(d_mean), .primed(d_pr));

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Feeds windows*2048 copies of v to A; a pulse is expected right after every 2048th accept.
  task automatic a_run(input logic [15:0] v, input int windows, input bit gaps, input string tag);
    int  acc_cnt = 0;
    int  pulses = 0;
    int  bad_pos = 0;
    int  bad_val = 0;
    bit  exp_pulse = 0;
    int  total = windows * 2048;
    while (acc_cnt < total || exp_pulse) begin
      @(negedge clk);
      if (a_vo !== exp_pulse) bad_pos++;
      if (a_vo === 1'b1) begin
        pulses++;
        if (a_mean !== v) bad_val++;
      end
      exp_pulse = 0;
      if (acc_cnt < total && !(gaps && $urandom_range(0, 3) == 0)) begin
        a_vi = 1'b1;
        a_d  = v;
        acc_cnt++;
        exp_pulse = (acc_cnt % 2048 == 0);
      end else begin
        a_vi = 1'b0;
      end
    end
    a_vi = 1'b0;
    check_val({tag, "_pulses"}, pulses, windows);
    check_val({tag, "_timing"}, bad_pos, 0);
    check_val({tag, "_value"}, bad_val, 0);
    check_val({tag, "_held"}, a_mean, v);
  endtask

  int b_vals [8];
  int b_exp_vo [8];
  int b_exp_mean [8];

  // Sliding sequence on B; primed is expected to track the first-result point.
  task automatic b_seq(input int n, input string tag);
    for (int i = 0; i <= n; i++) begin
      @(negedge clk);
      if (i > 0) begin
        check_val($sformatf("%s_vo%0d", tag, i), b_vo, b_exp_vo[i-1]);
        check_val($sformatf("%s_pr%0d", tag, i), b_pr, b_exp_vo[i-1]);
        check_val($sformatf("%s_mean%0d", tag, i), b_mean, b_exp_mean[i-1]);
      end
      if (i < n) begin
        b_vi = 1'b1;
        b_d  = 16'(b_vals[i]);
      end else begin
        b_vi = 1'b0;
      end
    end
  endtask

  task automatic cd_window(input logic [15:0] s0, s1, s2, s3,
                           input logic [15:0] exp_floor, exp_round, input string tag);
    logic [15:0] s [4];
    int early = 0;
    s = '{s0, s1, s2, s3};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i > 0 && (c_vo || d_vo)) early++;
      c_vi = 1'b1;
      c_d  = s[i];
    end
    @(negedge clk);
    c_vi = 1'b0;
    check_val({tag, "_early"}, early, 0);
    check_val({tag, "_vo_floor"}, c_vo, 1);
    check_val({tag, "_floor"}, c_mean, exp_floor);
    check_val({tag, "_vo_round"}, d_vo, 1);
    check_val({tag, "_round"}, d_mean, exp_round);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    #12;
    check_val("rst_a_vo", a_vo, 0);
    check_val("rst_a_mean", a_mean, 0);
    check_val("rst_b_pr", b_pr, 0);
    check_val("rst_b_mean", b_mean, 0);
    @(negedge clk);
    rst = 1'b0;

    a_run(16'h4000, 1, 0, "blk_4000");
    a_run(16'hC000, 1, 0, "blk_C000");
    a_run(16'h7FFF, 1, 0, "blk_7FFF");
    a_run(16'h8000, 1, 0, "blk_8000");
    a_run(16'h0666, 1, 1, "blk_gaps");
    a_run(16'h0666, 2, 0, "blk_b2b");

    // Partial window, then clear together with a sample that must be dropped.
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      a_vi = 1'b1;
      a_d  = 16'h7000;
    end
    @(negedge clk);
    a_clr = 1'b1;
    a_d   = 16'h7FFF;
    @(negedge clk);
    a_clr = 1'b0;
    a_vi  = 1'b0;
    check_val("clr_vo", a_vo, 0);
    check_val("clr_mean_held", a_mean, 16'h0666);
    a_run(16'h2000, 1, 0, "blk_post_clr");

    b_vals     = '{4, 8, 12, 16, 20, 24, 0, 0};
    b_exp_vo   = '{0, 0, 0, 1, 1, 1, 0, 0};
    b_exp_mean = '{0, 0, 0, 'h0A, 'h0E, 'h12, 0, 0};
    b_seq(6, "slide");
    @(negedge clk);
    check_val("slide_idle_vo", b_vo, 0);
    check_val("slide_idle_mean", b_mean, 16'h0012);

    cd_window(16'h0001, 16'h0001, 16'h0001, 16'h0000, 16'h0000, 16'h0001, "rnd_pos");
    cd_window(16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 16'hFFFF, 16'h0000, "rnd_neg");
    cd_window(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, "rnd_max");

    // Partial window on A, then a 3 ns reset pulse between clock edges.
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      a_vi = 1'b1;
      a_d  = 16'h7FFF;
    end
    @(negedge clk);
    a_vi = 1'b0;
    #1 rst = 1'b1;
    #1;
    check_val("arst_a_mean", a_mean, 0);
    check_val("arst_a_vo", a_vo, 0);
    check_val("arst_b_pr", b_pr, 0);
    check_val("arst_b_mean", b_mean, 0);
    #2 rst = 1'b0;

    b_vals     = '{1, 2, 3, 6, 0, 0, 0, 0};
    b_exp_vo   = '{0, 0, 0, 1, 0, 0, 0, 0};
    b_exp_mean = '{0, 0, 0, 3, 0, 0, 0, 0};
    b_seq(4, "slide_rst");

    a_run(16'h1000, 1, 0, "blk_post_rst");
    check_val("blk_primed", a_pr, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
